// File: rtl/full_case_decoder.sv
// Registered decoder for the 4-bit select code {a,b}, with a valid/ready capture and a held result.
// Define FULL_CASE_DEC_ERR_CNT_EN to build the saturating illegal-code counter; otherwise err_cnt is tied to 0.
module full_case_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dec_out,
  output logic             pri_out,
  output logic [15:0]      dec_onehot,
  output logic             dec_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        dec_out_q, dec_out_d;
  logic        pri_out_q, pri_out_d;
  logic [15:0] dec_onehot_q, dec_onehot_d;
  logic        dec_err_q, dec_err_d;
  logic        code_illegal;

  // Only codes with a == 2'b00 belong to the legal table.
  assign code_illegal = |code_q[3:2];

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    dec_out_d    = dec_out_q;
    pri_out_d    = pri_out_q;
    dec_onehot_d = dec_onehot_q;
    dec_err_d    = dec_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d     = {a, b};
          state_d    = DECODE;
          in_ready_d = 1'b0;
        end
      end

      DECODE: begin
        state_d     = HOLD;
        out_valid_d = 1'b1;

        case (code_q)
          4'b0000: begin dec_out_d = 1'b0; dec_err_d = 1'b0; end
          4'b0001: begin dec_out_d = 1'b1; dec_err_d = 1'b0; end
          4'b0010: begin dec_out_d = 1'b0; dec_err_d = 1'b0; end
          4'b0011: begin dec_out_d = 1'b1; dec_err_d = 1'b0; end
          default: begin dec_out_d = 1'b0; dec_err_d = 1'b1; end
        endcase

        // a[0]&b[0] wins, then a[1]|b[1] clears; otherwise pri_out_q is simply reloaded.
        if (code_q[2] & code_q[0]) begin
          pri_out_d = 1'b1;
        end else if (code_q[3] | code_q[1]) begin
          pri_out_d = 1'b0;
        end

        dec_onehot_d = 16'd1 << code_q;
      end

      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= 4'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      dec_out_q    <= 1'b0;
      pri_out_q    <= 1'b0;
      dec_onehot_q <= 16'd0;
      dec_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      dec_out_q    <= dec_out_d;
      pri_out_q    <= pri_out_d;
      dec_onehot_q <= dec_onehot_d;
      dec_err_q    <= dec_err_d;
    end
  end

`ifdef FULL_CASE_DEC_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Saturate rather than wrap so a flood of bad codes never reads as a small count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == DECODE) && code_illegal && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_illegal;
  assign unused_illegal = code_illegal;
  assign err_cnt        = {ERR_W{1'b0}};
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign dec_out    = dec_out_q;
  assign pri_out    = pri_out_q;
  assign dec_onehot = dec_onehot_q;
  assign dec_err    = dec_err_q;

endmodule

// File: tb/tb_full_case_decoder.sv
// Directed self-checking bench for full_case_decoder, one task per scenario.
// Expected err_cnt follows FULL_CASE_DEC_ERR_CNT_EN, matching the build of the design.
module tb_full_case_decoder;

  localparam int ERR_W = 2;
`ifdef FULL_CASE_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [1:0]       a;
  logic [1:0]       b;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             dec_out;
  logic             pri_out;
  logic [15:0]      dec_onehot;
  logic             dec_err;
  logic [ERR_W-1:0] err_cnt;

  int n_checks;
  int n_fail;

  full_case_decoder #(.ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dec_out   (dec_out),
    .pri_out   (pri_out),
    .dec_onehot(dec_onehot),
    .dec_err   (dec_err),
    .err_cnt   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a code, let it be accepted, and stop one step after the decode edge (in HOLD).
  task automatic send(input logic [3:0] code, input logic rdy);
    a         = code[3:2];
    b         = code[1:0];
    in_valid  = 1'b1;
    out_ready = rdy;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({in_ready, out_valid, dec_out, pri_out, dec_err} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got %b expected 10000", {in_ready, out_valid, dec_out, pri_out, dec_err});
    end
    n_checks++;
    if (dec_onehot !== 16'h0000 || err_cnt !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_vals got onehot=%h cnt=%0d expected 0000/0", dec_onehot, err_cnt);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dec_onehot !== 16'h0000) begin
        n_fail++;
        $display("[TB] FAIL idle_%0d got rdy=%b vld=%b onehot=%h expected 1/0/0000", i, in_ready, out_valid, dec_onehot);
      end
    end
  endtask

  task automatic test_legal();
    a = 2'b00; b = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL legal_decode_state got rdy=%b vld=%b expected 0/0", in_ready, out_valid);
    end
    tick();
    n_checks++;
    if ({out_valid, dec_out, pri_out, dec_err} !== 4'b1100 || dec_onehot !== 16'h0002) begin
      n_fail++;
      $display("[TB] FAIL legal_result got vld/dec/pri/err=%b onehot=%h expected 1100/0002",
               {out_valid, dec_out, pri_out, dec_err}, dec_onehot);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dec_onehot !== 16'h0002) begin
      n_fail++;
      $display("[TB] FAIL legal_release got vld=%b rdy=%b onehot=%h expected 0/1/0002", out_valid, in_ready, dec_onehot);
    end
  endtask

  task automatic test_priority();
    send(4'b0101, 1'b1);
    n_checks++;
    if (pri_out !== 1'b1 || dec_err !== 1'b1 || dec_onehot !== 16'h0020) begin
      n_fail++;
      $display("[TB] FAIL pri_set got pri=%b err=%b onehot=%h expected 1/1/0020", pri_out, dec_err, dec_onehot);
    end
    tick();
    send(4'b0000, 1'b1);
    n_checks++;
    if (pri_out !== 1'b1 || dec_out !== 1'b0 || dec_err !== 1'b0 || dec_onehot !== 16'h0001) begin
      n_fail++;
      $display("[TB] FAIL pri_hold got pri=%b dec=%b err=%b onehot=%h expected 1/0/0/0001", pri_out, dec_out, dec_err, dec_onehot);
    end
    tick();
    send(4'b1000, 1'b1);
    n_checks++;
    if (pri_out !== 1'b0 || dec_err !== 1'b1 || dec_onehot !== 16'h0100) begin
      n_fail++;
      $display("[TB] FAIL pri_clear got pri=%b err=%b onehot=%h expected 0/1/0100", pri_out, dec_err, dec_onehot);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [ERR_W-1:0] cnt_before;
    cnt_before = err_cnt;
    send(4'b0011, 1'b0);
    a = 2'b11; b = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out_valid, in_ready, dec_out, pri_out, dec_err} !== 5'b10100 || dec_onehot !== 16'h0008
          || err_cnt !== cnt_before) begin
        n_fail++;
        $display("[TB] FAIL bp_hold_%0d got vld/rdy/dec/pri/err=%b onehot=%h cnt=%0d expected 10100/0008/%0d",
                 i, {out_valid, in_ready, dec_out, pri_out, dec_err}, dec_onehot, err_cnt, cnt_before);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dec_out !== 1'b1 || dec_onehot !== 16'h0008) begin
      n_fail++;
      $display("[TB] FAIL bp_release got vld=%b rdy=%b dec=%b onehot=%h expected 0/1/1/0008", out_valid, in_ready, dec_out, dec_onehot);
    end
  endtask

  task automatic test_illegal();
    logic [ERR_W-1:0] exp_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(4'b1111, 1'b1);
      exp_cnt = CNT_EN ? ((i < 3) ? ERR_W'(i + 1) : 2'd3) : 2'd0;
      n_checks++;
      if ({out_valid, dec_err, dec_out, pri_out} !== 4'b1101 || dec_onehot !== 16'h8000 || err_cnt !== exp_cnt) begin
        n_fail++;
        $display("[TB] FAIL illegal_%0d got vld/err/dec/pri=%b onehot=%h cnt=%0d expected 1101/8000/%0d",
                 i, {out_valid, dec_err, dec_out, pri_out}, dec_onehot, err_cnt, exp_cnt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_hold();
    send(4'b1111, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || err_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL midrst_pre got vld=%b cnt=%0d", out_valid, err_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, dec_err, pri_out} !== 4'b0100 || err_cnt !== 2'd0 || dec_onehot !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL midrst_async got vld/rdy/err/pri=%b cnt=%0d onehot=%h expected 0100/0/0000",
               {out_valid, in_ready, dec_err, pri_out}, err_cnt, dec_onehot);
    end
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    a = 2'b00; b = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_hold got vld=%b rdy=%b expected 1/0", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle got vld=%b rdy=%b expected 0/1", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_reaccept got rdy=%b vld=%b expected 0/0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || dec_onehot !== 16'h0008 || dec_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_second got vld=%b onehot=%h dec=%b expected 1/0008/1", out_valid, dec_onehot, dec_out);
    end
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    a         = 2'b00;
    b         = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_legal();
    test_priority();
    test_backpressure();
    test_illegal();
    test_reset_mid_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
